// File: rtl/lsu_pkg.sv
// Purpose : shared types and constants for the load/store unit.
// Latency : n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b011,
        LD_HU = 3'b100
    } ld_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    localparam logic [3:0] BMASK_B = 4'b0001;
    localparam logic [3:0] BMASK_H = 4'b0011;
    localparam logic [3:0] BMASK_W = 4'b1111;

    // Stores are sized by their lane mask, loads by ld_sel.
    function automatic logic is_misaligned(input logic       wr_en,
                                           input logic [3:0] bmask,
                                           input logic [2:0] ld_sel,
                                           input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (wr_en) begin
            if (bmask == BMASK_H && off[0])      bad = 1'b1;
            if (bmask == BMASK_W && off != 2'b0) bad = 1'b1;
        end else begin
            if ((ld_sel == LD_H || ld_sel == LD_HU) && off[0]) bad = 1'b1;
            if (ld_sel == LD_W && off != 2'b0)                  bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Purpose : picks the addressed byte/half/word from an SRAM read word and extends it.
// Latency : combinational.
// Backpressure: none.
// Ports: rdata (SRAM word), off (byte offset addr[1:0]), ld_sel (load type),
//        ld_data (aligned, extended result; 0 for undefined ld_sel).
module lsu_ld_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_sel,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = rdata[8*off +: 8];
        // Halves are picked by addr[1] only; addr[0] is screened out upstream.
        half_v  = off[1] ? rdata[31:16] : rdata[15:0];
        ld_data = '0;
        case (ld_sel)
            LD_B:    ld_data = {{24{byte_v[7]}}, byte_v};
            LD_H:    ld_data = {{16{half_v[15]}}, half_v};
            LD_W:    ld_data = rdata;
            LD_BU:   ld_data = {24'b0, byte_v};
            LD_HU:   ld_data = {16'b0, half_v};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// Purpose : load/store unit driving a single-port variable-latency SRAM via req/ack.
// Latency : 2 stall cycles with zero-wait SRAM, N+1 for N REQ cycles, 1 on misalign.
// Backpressure: stall held while an access is in flight; TIMEOUT REQ cycles abort it.
// Ports: decoder controls (mem_req, wr_en, bmask, ld_sel), execute operands (addr,
//        st_data), writeback result and flags (ld_data, stall, misalign, timeout),
//        SRAM side (sram_req/we/addr/wdata/bmask out, sram_ack/rdata in).
module lsu_sram_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              wr_en,
    input  logic [3:0]        bmask,
    input  logic [2:0]        ld_sel,
    input  logic [31:0]       addr,
    input  logic [31:0]       st_data,
    output logic [31:0]       ld_data,
    output logic              stall,
    output logic              misalign,
    output logic              timeout,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic [3:0]        sram_bmask,
    input  logic              sram_ack,
    input  logic [31:0]       sram_rdata
);

    // The counter runs 0..TIMEOUT-1 across the REQ cycles.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       sel_q;
    logic [1:0]       off_q;
    logic             misaligned;
    logic [31:0]      align_data;

    // Upper byte-address bits fall outside the SRAM and are ignored.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    assign misaligned = is_misaligned(wr_en, bmask, ld_sel, addr[1:0]);

    lsu_ld_align u_ld_align (
        .rdata   (sram_rdata),
        .off     (off_q),
        .ld_sel  (sel_q),
        .ld_data (align_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_req) begin
                    stall     = 1'b1;
                    state_nxt = misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (sram_ack || cnt == CNT_LAST) state_nxt = S_DONE;
            end
            // mem_req is still up here for the same instruction; never restart.
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_data    <= '0;
            misalign   <= 1'b0;
            timeout    <= 1'b0;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_bmask <= '0;
            cnt        <= '0;
            sel_q      <= '0;
            off_q      <= '0;
        end else begin
            misalign <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        if (misaligned) begin
                            misalign <= 1'b1;
                            ld_data  <= '0;
                        end else begin
                            sram_req   <= 1'b1;
                            sram_we    <= wr_en;
                            sram_addr  <= addr[ADDR_W+1:2];
                            sram_bmask <= bmask << addr[1:0];
                            sram_wdata <= st_data << {addr[1:0], 3'b000};
                            sel_q      <= ld_sel;
                            off_q      <= addr[1:0];
                            cnt        <= '0;
                        end
                    end
                end
                S_REQ: begin
                    // An ack in the last allowed cycle still completes the access.
                    if (sram_ack) begin
                        sram_req <= 1'b0;
                        ld_data  <= sram_we ? 32'b0 : align_data;
                    end else if (cnt == CNT_LAST) begin
                        sram_req <= 1'b0;
                        timeout  <= 1'b1;
                        ld_data  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lsu_sram_ctrl.md
# lsu_sram_ctrl

Load/store unit that consumes the decoder's memory controls (`wr_en`, `bmask`, `ld_sel`) and carries them out against a single-port, variable-latency data SRAM with a req/ack handshake. It sits between the execute stage (ALU address, rs2 data) and the writeback mux (`ld_data`, selected by `wb_sel = 01`). It asserts `stall` to freeze the PC and register file while an access is in flight.

## Interface

**Parameters**
- `ADDR_W`, default 16: SRAM word-address width; the byte address uses bits `[ADDR_W+1:2]`.
- `TIMEOUT`, default 255: maximum number of REQ cycles waiting for `sram_ack` before the access is aborted.

**Ports** (clock and reset first)
- `clk`, in, 1: the single clock. All state updates on its rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `mem_req`, in, 1: the current instruction is a load or store (decoder `wb_sel==01 | wr_en`).
- `wr_en`, in, 1: 1 = store, 0 = load.
- `bmask`, in, 4: store lanes, unshifted: `0001` sb, `0011` sh, `1111` sw.
- `ld_sel`, in, 3: `000` lb, `001` lh, `010` lw, `011` lbu, `100` lhu.
- `addr`, in, 32: byte address from the ALU.
- `st_data`, in, 32: rs2 data.
- `ld_data`, out, 32: aligned, extended load result.
- `stall`, out, 1: hold PC and suppress register-file write.
- `misalign`, out, 1: one-cycle flag; the access was rejected.
- `timeout`, out, 1: one-cycle flag; the access was aborted.
- `sram_req`, out, 1: SRAM request.
- `sram_we`, out, 1: SRAM write.
- `sram_addr`, out, ADDR_W: SRAM word address.
- `sram_wdata`, out, 32: lane-shifted store data.
- `sram_bmask`, out, 4: lane-shifted byte enables.
- `sram_ack`, in, 1: SRAM completion (write done, or read data valid this cycle).
- `sram_rdata`, in, 32: SRAM read word.

## Operation

**States:** IDLE, REQ, DONE.

**IDLE**
- `mem_req=0`: stay in IDLE; `stall=0`.
- `mem_req=1`: `stall=1` (combinational). The request is checked for misalignment:
  - lh/lhu/sh with `addr[0]=1`, or lw/sw with `addr[1:0]≠0`, is misaligned.
  - Misaligned: go to DONE with `misalign` set, no SRAM access, `ld_data=0`.
  - Aligned: register the following, then go to REQ.
    - `sram_addr = addr[ADDR_W+1:2]`
    - `sram_we = wr_en`
    - `sram_bmask = bmask << addr[1:0]`
    - `sram_wdata = st_data << 8*addr[1:0]`
    - `ld_sel` and `addr[1:0]`

**REQ**
- `sram_req=1`; all `sram_*` outputs held stable; `stall=1`.
- `sram_ack=1`: capture `sram_rdata` (loads only) and go to DONE.
- Wait counter reaches TIMEOUT without ack: drop `sram_req`, go to DONE with `timeout` set, `ld_data=0`.

**DONE**
- `stall=0`; `ld_data` is valid; `misalign`/`timeout` are visible this cycle only.
- The core commits and advances the PC at this edge.
- Always return to IDLE. `mem_req` seen in DONE belongs to the same instruction and never restarts an access.

**Load extraction**
- Byte = `rdata` lane `addr[1:0]`; half = lane pair `addr[1]`.
- lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Undefined `ld_sel` (`101`–`111`) returns 0.

**Store behaviour**
- `ld_data=0` for stores.

**Boundary behaviour**
- `sram_ack` is ignored outside REQ.
- A new `mem_req` is accepted only in IDLE.
- `rst` asserted mid-access:
  - go to IDLE next edge, drop `sram_req`, clear the counter;
  - any later ack is ignored.

## Timing

**Reset values:** state=IDLE; `stall=0`, `misalign=0`, `timeout=0`, `ld_data=0`, `sram_req=0`, `sram_we=0`, `sram_addr=0`, `sram_wdata=0`, `sram_bmask=0`.

**Zero-wait SRAM (ack in first REQ cycle)**
- Cycle 0: IDLE, `stall=1`.
- Cycle 1: REQ, ack.
- Cycle 2: DONE, `stall=0`.
- Minimum cost: 2 stall cycles per memory instruction.

**N-cycle ack latency:** `N+1` stall cycles.

**Misaligned access:** exactly 1 stall cycle.

**Timeout:** `TIMEOUT+1` stall cycles.

**Registered vs. combinational outputs**
- `stall` is combinational from state and `mem_req`.
- All `sram_*` outputs, `ld_data`, `misalign` and `timeout` are registered.

## Structure

- Package `lsu_pkg`:
  - `ld_sel_e` enum: `LD_B`, `LD_H`, `LD_W`, `LD_BU`, `LD_HU` with the encodings above.
  - `lsu_state_e` enum.
  - `BMASK_B`/`BMASK_H`/`BMASK_W` constants.
- Sub-module `lsu_ld_align`: combinational lane select and sign/zero extension from (`rdata`, `addr[1:0]`, `ld_sel`). Instantiated once and unit-tested separately.

## Test plan

- **sw**, `addr=0x0000_0010`, `st_data=0xDEADBEEF`, ack on first REQ cycle → `sram_addr=4`, `sram_bmask=1111`, `sram_wdata=0xDEADBEEF`, `sram_we=1`; `stall` high exactly 2 cycles.
- **sb**, `addr=0x13`, `st_data=0x0000_00A5` → `sram_bmask=1000`, `sram_wdata=0xA500_0000`.
- **lb / lbu**, `addr=0x02`, SRAM word `0x1280_FF34`:
  - lb → `ld_data=0x0000_0080`? No: lane 2 is `0x80`, so lb → `0xFFFF_FF80` and lbu → `0x0000_0080`.
  - Same word, lh at `addr=0x02` → `0x0000_1280`.
- **lw** with ack delayed 5 cycles → `sram_req` and `sram_addr` stable for 5 REQ cycles; `stall` high 6 cycles; `ld_data` equals `sram_rdata` in DONE.
- **lh** at `addr=0x01` → `misalign` pulses in the cycle after the request, `sram_req` never asserts, `stall` is 1 cycle, `ld_data=0`.
- **Fault and reset**, `TIMEOUT=3` with no ack → `timeout` pulses after 3 REQ cycles and `sram_req` drops. Separately, `rst` in REQ → next cycle IDLE, all outputs at reset values; a late ack produces no DONE.
